// File: rtl/axis_frame_writer.sv
// axis_frame_writer: places an AXI4-Stream video frame (TUSER = start of frame,
// TLAST = end of line) into a linear frame buffer at BASE_ADDR + y*H_PIXELS + x.
// It realigns on SOF, checks line length and resynchronises after a bad line,
// pulses frame_done with the last write of a frame, counts completed frames and
// keeps sticky error flags.
//
// state        | meaning
// -------------|------------------------------------------------------------
// ST_WAIT_SOF  | idle between frames; beats without TUSER are dropped
// ST_ACTIVE    | inside a frame; every beat is written at (x,y)
// ST_DROP_LINE | line overran H_PIXELS; drop beats up to and including TLAST
module axis_frame_writer #(
  parameter int          H_PIXELS  = 640,
  parameter int          V_LINES   = 480,
  parameter int          DATA_W    = 24,
  parameter int          ADDR_W    = 20,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              s_axis_tvalid_i,
  output logic              s_axis_tready_o,
  input  logic [DATA_W-1:0] s_axis_tdata_i,
  input  logic              s_axis_tuser_i,
  input  logic              s_axis_tlast_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_cnt_o,
  input  logic              err_clr_i,
  output logic [2:0]        err_o
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  localparam logic [XW-1:0]     X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

  localparam longint unsigned LAST_ADDR =
    64'(BASE_ADDR) + 64'(H_PIXELS) * 64'(V_LINES) - 64'd1;

  // The whole frame must fit in the write address range.
  if (ADDR_W < 64 && (LAST_ADDR >> ADDR_W) != 64'd0) begin : g_addr_overflow
    $error("axis_frame_writer: BASE_ADDR + H_PIXELS*V_LINES - 1 does not fit in ADDR_W bits");
  end

  typedef enum logic [1:0] {
    ST_WAIT_SOF  = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_DROP_LINE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                tready_q;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [2:0]          err_q, err_d;

  logic                beat;
  logic                restart;
  logic                eol;
  logic [2:0]          err_set;
  logic [XW-1:0]       cur_x;
  logic [YW-1:0]       cur_y;
  logic [ADDR_W-1:0]   cur_base;

  assign beat = s_axis_tvalid_i & tready_q;

  // Next-state, pixel position, write strobe and error logic for one beat.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_set      = 3'b000;
    restart      = 1'b0;
    eol          = 1'b0;
    cur_x        = x_q;
    cur_y        = y_q;
    cur_base     = base_q;

    if (beat) begin
      // SOF always realigns to pixel (0,0); it is only an error inside a frame.
      if (s_axis_tuser_i) begin
        if (state_q == ST_WAIT_SOF) begin
          restart = 1'b1;
        end else if (state_q == ST_DROP_LINE || x_q != '0 || y_q != '0) begin
          restart    = 1'b1;
          err_set[2] = 1'b1;
        end
      end

      if (restart) begin
        cur_x    = '0;
        cur_y    = '0;
        cur_base = BASE;
      end

      if (restart || state_q == ST_ACTIVE) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cur_base + ADDR_W'(cur_x);
        wr_data_d = s_axis_tdata_i;
        if (s_axis_tlast_i) begin
          eol = 1'b1;
          if (cur_x != X_LAST) err_set[0] = 1'b1;
        end else if (cur_x == X_LAST) begin
          err_set[1] = 1'b1;
          state_d    = ST_DROP_LINE;
          x_d        = cur_x;
          y_d        = cur_y;
          base_d     = cur_base;
        end else begin
          state_d = ST_ACTIVE;
          x_d     = cur_x + 1'b1;
          y_d     = cur_y;
          base_d  = cur_base;
        end
      end else if (state_q == ST_DROP_LINE && s_axis_tlast_i) begin
        eol = 1'b1;
      end

      // A line ends either normally, early, or after dropping an overrun.
      if (eol) begin
        if (cur_y == Y_LAST) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          state_d      = ST_WAIT_SOF;
          x_d          = '0;
          y_d          = '0;
          base_d       = BASE;
        end else begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = cur_y + 1'b1;
          base_d  = cur_base + H_STEP;
        end
      end
    end

    // New errors survive a simultaneous clear.
    err_d = err_clr_i ? err_set : (err_q | err_set);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_WAIT_SOF;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= BASE;
      tready_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      base_q       <= base_d;
      tready_q     <= en_i;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
    end
  end

  assign s_axis_tready_o = tready_q;
  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign frame_done_o    = frame_done_q;
  assign frame_cnt_o     = frame_cnt_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_axis_frame_writer.sv
// Directed bench for axis_frame_writer with H=4, V=3, BASE=0x100.
module tb_axis_frame_writer;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        en_i = 1'b0;
  logic        s_axis_tvalid_i = 1'b0;
  logic        s_axis_tready_o;
  logic [23:0] s_axis_tdata_i = '0;
  logic        s_axis_tuser_i = 1'b0;
  logic        s_axis_tlast_i = 1'b0;
  logic        wr_en_o;
  logic [19:0] wr_addr_o;
  logic [23:0] wr_data_o;
  logic        frame_done_o;
  logic [15:0] frame_cnt_o;
  logic        err_clr_i = 1'b0;
  logic [2:0]  err_o;

  int tests = 0;
  int fails = 0;

  logic [19:0] cap_a[$];
  logic [23:0] cap_d[$];
  logic        cap_f[$];
  logic [19:0] exp_a[$];
  logic [23:0] exp_d[$];
  logic        exp_f[$];

  axis_frame_writer #(
    .H_PIXELS (4),
    .V_LINES  (3),
    .DATA_W   (24),
    .ADDR_W   (20),
    .BASE_ADDR(32'h100)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .en_i           (en_i),
    .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tready_o(s_axis_tready_o),
    .s_axis_tdata_i (s_axis_tdata_i),
    .s_axis_tuser_i (s_axis_tuser_i),
    .s_axis_tlast_i (s_axis_tlast_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .frame_done_o   (frame_done_o),
    .frame_cnt_o    (frame_cnt_o),
    .err_clr_i      (err_clr_i),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every frame-buffer write shortly after the clock edge.
  always @(posedge clk_i) begin
    #1;
    if (wr_en_o) begin
      cap_a.push_back(wr_addr_o);
      cap_d.push_back(wr_data_o);
      cap_f.push_back(frame_done_o);
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    s_axis_tvalid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    cap_a.delete(); cap_d.delete(); cap_f.delete();
    exp_a.delete(); exp_d.delete(); exp_f.delete();
  endtask

  task automatic expect_wr(input logic [19:0] a, input logic [23:0] d, input logic f);
    exp_a.push_back(a);
    exp_d.push_back(d);
    exp_f.push_back(f);
  endtask

  // One beat: waits for ready, holds the beat for exactly one rising edge.
  task automatic send(input logic u, input logic l, input logic [23:0] d, input logic clr);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!s_axis_tready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!s_axis_tready_o) begin
      tests++; fails++;
      $display("FAIL ready_timeout: tready=%0b want 1", s_axis_tready_o);
    end
    s_axis_tvalid_i = 1'b1;
    s_axis_tuser_i  = u;
    s_axis_tlast_i  = l;
    s_axis_tdata_i  = d;
    err_clr_i       = clr;
    @(posedge clk_i);
    #1;
    s_axis_tvalid_i = 1'b0;
    s_axis_tuser_i  = 1'b0;
    s_axis_tlast_i  = 1'b0;
    err_clr_i       = 1'b0;
  endtask

  // Clean 4x3 frame starting at data d0; expects writes 0x100..0x10B.
  task automatic clean_frame(input logic [23:0] d0);
    for (int i = 0; i < 12; i++) begin
      send(i == 0, (i % 4) == 3, d0 + 24'(i), 1'b0);
      expect_wr(20'h100 + 20'(i), d0 + 24'(i), i == 11);
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    en_i = 1'b1;
    tests++;
    if ({s_axis_tready_o, wr_en_o, frame_done_o} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: tready/wr_en/done=%b want 000",
               {s_axis_tready_o, wr_en_o, frame_done_o});
    end
    tests++;
    if ({wr_addr_o, wr_data_o, frame_cnt_o, err_o} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%h data=%h cnt=%0d err=%b want all 0",
               wr_addr_o, wr_data_o, frame_cnt_o, err_o);
    end
    @(negedge clk_i);
    tests++;
    if (s_axis_tready_o !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_en: got %b want 1", s_axis_tready_o);
    end
  endtask

  task automatic test_clean_frame();
    do_reset();
    clean_frame(24'hA00000);
    tests++;
    if (cap_a.size() != exp_a.size()) begin
      fails++;
      $display("FAIL clean_count: got %0d writes want %0d", cap_a.size(), exp_a.size());
    end else foreach (exp_a[i]) begin
      tests++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i]) begin
        fails++;
        $display("FAIL clean_wr%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_a[i], cap_d[i], cap_f[i], exp_a[i], exp_d[i], exp_f[i]);
      end
    end
    tests++;
    if (frame_cnt_o !== 16'd1 || err_o !== 3'b000) begin
      fails++;
      $display("FAIL clean_status: cnt=%0d err=%b want 1/000", frame_cnt_o, err_o);
    end
  endtask

  task automatic test_pre_sof_junk();
    do_reset();
    for (int i = 0; i < 5; i++) send(1'b0, i == 2, 24'hBAD000 + 24'(i), 1'b0);
    clean_frame(24'hB00000);
    tests++;
    if (cap_a.size() != exp_a.size()) begin
      fails++;
      $display("FAIL junk_count: got %0d writes want %0d", cap_a.size(), exp_a.size());
    end else foreach (exp_a[i]) begin
      tests++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i]) begin
        fails++;
        $display("FAIL junk_wr%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_a[i], cap_d[i], cap_f[i], exp_a[i], exp_d[i], exp_f[i]);
      end
    end
    tests++;
    if (frame_cnt_o !== 16'd1 || err_o !== 3'b000) begin
      fails++;
      $display("FAIL junk_status: cnt=%0d err=%b want 1/000", frame_cnt_o, err_o);
    end
  endtask

  task automatic test_early_tlast();
    do_reset();
    // Line 0 ends at x=2; lines 1 and 2 are complete.
    for (int i = 0; i < 3; i++) begin
      send(i == 0, i == 2, 24'hC00000 + 24'(i), 1'b0);
      expect_wr(20'h100 + 20'(i), 24'hC00000 + 24'(i), 1'b0);
    end
    tests++;
    if (err_o !== 3'b001) begin
      fails++;
      $display("FAIL early_err_timing: got %b want 001", err_o);
    end
    for (int i = 0; i < 8; i++) begin
      send(1'b0, (i % 4) == 3, 24'hC10000 + 24'(i), 1'b0);
      expect_wr(20'h104 + 20'(i), 24'hC10000 + 24'(i), i == 7);
    end
    repeat (3) @(negedge clk_i);
    tests++;
    if (cap_a.size() != exp_a.size()) begin
      fails++;
      $display("FAIL early_count: got %0d writes want %0d", cap_a.size(), exp_a.size());
    end else foreach (exp_a[i]) begin
      tests++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i]) begin
        fails++;
        $display("FAIL early_wr%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_a[i], cap_d[i], cap_f[i], exp_a[i], exp_d[i], exp_f[i]);
      end
    end
    tests++;
    if (frame_cnt_o !== 16'd1 || err_o !== 3'b001) begin
      fails++;
      $display("FAIL early_status: cnt=%0d err=%b want 1/001", frame_cnt_o, err_o);
    end
  endtask

  task automatic test_missing_tlast();
    do_reset();
    // Lines 0 and 1: four pixels each, line 1 has no TLAST.
    for (int i = 0; i < 8; i++) begin
      send(i == 0, i == 3, 24'hD00000 + 24'(i), 1'b0);
      expect_wr(20'h100 + 20'(i), 24'hD00000 + 24'(i), 1'b0);
    end
    send(1'b0, 1'b0, 24'hDEAD01, 1'b0);
    send(1'b0, 1'b1, 24'hDEAD02, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, i == 3, 24'hD10000 + 24'(i), 1'b0);
      expect_wr(20'h108 + 20'(i), 24'hD10000 + 24'(i), i == 3);
    end
    repeat (3) @(negedge clk_i);
    tests++;
    if (cap_a.size() != exp_a.size()) begin
      fails++;
      $display("FAIL missing_count: got %0d writes want %0d", cap_a.size(), exp_a.size());
    end else foreach (exp_a[i]) begin
      tests++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i]) begin
        fails++;
        $display("FAIL missing_wr%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_a[i], cap_d[i], cap_f[i], exp_a[i], exp_d[i], exp_f[i]);
      end
    end
    tests++;
    if (frame_cnt_o !== 16'd1 || err_o !== 3'b010) begin
      fails++;
      $display("FAIL missing_status: cnt=%0d err=%b want 1/010", frame_cnt_o, err_o);
    end
  endtask

  task automatic test_sof_mid_frame();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(i == 0, i == 3, 24'hE00000 + 24'(i), 1'b0);
      expect_wr(20'h100 + 20'(i), 24'hE00000 + 24'(i), 1'b0);
    end
    // SOF at (1,1) restarts the frame at 0x100.
    for (int i = 0; i < 12; i++) begin
      send(i == 0, (i % 4) == 3, 24'hE10000 + 24'(i), 1'b0);
      expect_wr(20'h100 + 20'(i), 24'hE10000 + 24'(i), i == 11);
    end
    repeat (3) @(negedge clk_i);
    tests++;
    if (cap_a.size() != exp_a.size()) begin
      fails++;
      $display("FAIL sof_count: got %0d writes want %0d", cap_a.size(), exp_a.size());
    end else foreach (exp_a[i]) begin
      tests++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i]) begin
        fails++;
        $display("FAIL sof_wr%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_a[i], cap_d[i], cap_f[i], exp_a[i], exp_d[i], exp_f[i]);
      end
    end
    tests++;
    if (frame_cnt_o !== 16'd1 || err_o !== 3'b100) begin
      fails++;
      $display("FAIL sof_status: cnt=%0d err=%b want 1/100", frame_cnt_o, err_o);
    end
  endtask

  task automatic test_stall_clear_reset();
    do_reset();
    send(1'b1, 1'b0, 24'hF00000, 1'b0);
    expect_wr(20'h100, 24'hF00000, 1'b0);
    send(1'b0, 1'b0, 24'hF00001, 1'b0);
    expect_wr(20'h101, 24'hF00001, 1'b0);
    @(negedge clk_i);
    en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++;
    if (s_axis_tready_o !== 1'b0 || wr_en_o !== 1'b0) begin
      fails++;
      $display("FAIL en_low: tready=%b wr_en=%b want 0/0", s_axis_tready_o, wr_en_o);
    end
    en_i = 1'b1;
    send(1'b0, 1'b0, 24'hF00002, 1'b0);
    expect_wr(20'h102, 24'hF00002, 1'b0);
    repeat (3) @(negedge clk_i);
    for (int i = 3; i < 12; i++) begin
      send(1'b0, (i % 4) == 3, 24'hF00000 + 24'(i), 1'b0);
      expect_wr(20'h100 + 20'(i), 24'hF00000 + 24'(i), i == 11);
    end
    repeat (3) @(negedge clk_i);
    tests++;
    if (cap_a.size() != exp_a.size()) begin
      fails++;
      $display("FAIL stall_count: got %0d writes want %0d", cap_a.size(), exp_a.size());
    end else foreach (exp_a[i]) begin
      tests++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i]) begin
        fails++;
        $display("FAIL stall_wr%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_a[i], cap_d[i], cap_f[i], exp_a[i], exp_d[i], exp_f[i]);
      end
    end
    tests++;
    if (frame_cnt_o !== 16'd1 || err_o !== 3'b000) begin
      fails++;
      $display("FAIL stall_status: cnt=%0d err=%b want 1/000", frame_cnt_o, err_o);
    end

    // Single-beat SOF+EOL, then SOF at (0,1) together with a clear.
    send(1'b1, 1'b1, 24'h123456, 1'b0);
    tests++;
    if (err_o !== 3'b001 || wr_addr_o !== 20'h100) begin
      fails++;
      $display("FAIL sof_eol_beat: err=%b addr=%h want 001/100", err_o, wr_addr_o);
    end
    send(1'b1, 1'b0, 24'h654321, 1'b1);
    tests++;
    if (err_o !== 3'b100 || wr_addr_o !== 20'h100) begin
      fails++;
      $display("FAIL clr_vs_set: err=%b addr=%h want 100/100", err_o, wr_addr_o);
    end
    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    tests++;
    if (err_o !== 3'b000) begin
      fails++;
      $display("FAIL err_clear: got %b want 000", err_o);
    end

    // Reset in the middle of a frame.
    send(1'b0, 1'b0, 24'h777777, 1'b0);
    do_reset();
    tests++;
    if ({s_axis_tready_o, wr_en_o, frame_done_o, wr_addr_o, wr_data_o, frame_cnt_o, err_o} !== '0) begin
      fails++;
      $display("FAIL midframe_reset: tready=%b wr_en=%b addr=%h data=%h cnt=%0d err=%b want all 0",
               s_axis_tready_o, wr_en_o, wr_addr_o, wr_data_o, frame_cnt_o, err_o);
    end
    send(1'b0, 1'b1, 24'h888888, 1'b0);
    clean_frame(24'h900000);
    tests++;
    if (cap_a.size() != exp_a.size()) begin
      fails++;
      $display("FAIL post_reset_count: got %0d writes want %0d", cap_a.size(), exp_a.size());
    end else foreach (exp_a[i]) begin
      tests++;
      if (cap_a[i] !== exp_a[i] || cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i]) begin
        fails++;
        $display("FAIL post_reset_wr%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_a[i], cap_d[i], cap_f[i], exp_a[i], exp_d[i], exp_f[i]);
      end
    end
    tests++;
    if (frame_cnt_o !== 16'd1 || err_o !== 3'b000) begin
      fails++;
      $display("FAIL post_reset_status: cnt=%0d err=%b want 1/000", frame_cnt_o, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_pre_sof_junk();
    test_early_tlast();
    test_missing_tlast();
    test_sof_mid_frame();
    test_stall_clear_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
